// File: rtl/lm80c_ram_arbiter.sv
// rtl/lm80c_ram_arbiter.sv - Z80 / program-loader arbiter for the shared 8-bit system RAM port.
// Optional CPU write protection of the ROM shadow window: define ARB_WRITE_PROTECT_EN.
module lm80c_ram_arbiter #(
  parameter int             AW          = 16,
  parameter int             DW          = 8,
  parameter int             RAM_LAT     = 1,
  parameter int             LD_MAX_SKIP = 4,
  parameter logic [AW-1:0]  WP_BASE     = AW'(16'h0000),
  parameter logic [AW-1:0]  WP_LIMIT    = AW'(16'h7FFF)
) (
  input  logic          sys_clock,
  input  logic          RESET,
  input  logic          cpu_req_i,
  input  logic          cpu_we_i,
  input  logic [AW-1:0] cpu_addr_i,
  input  logic [DW-1:0] cpu_wdata_i,
  output logic [DW-1:0] cpu_rdata_o,
  output logic          cpu_ack_o,
  output logic          cpu_wait_o,
  input  logic          ld_req_i,
  input  logic [AW-1:0] ld_addr_i,
  input  logic [DW-1:0] ld_wdata_i,
  output logic          ld_ack_o,
  output logic [AW-1:0] ram_addr_o,
  output logic [DW-1:0] ram_dout_o,
  input  logic [DW-1:0] ram_din_i,
  output logic          ram_rd_o,
  output logic          ram_wr_o
);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_LAT, S_DONE} state_t;

`ifdef ARB_WRITE_PROTECT_EN
  localparam bit WP_EN = 1'b1;
`else
  localparam bit WP_EN = 1'b0;
`endif

  localparam logic [2:0] SKIP_MAX = 3'(LD_MAX_SKIP);
  localparam logic [2:0] LAT_LAST = 3'(RAM_LAT - 1);

  state_t        state_q, state_d;
  logic          owner_ld_q, owner_ld_d;
  logic          is_wr_q, is_wr_d;
  logic [2:0]    lat_cnt_q, lat_cnt_d;
  logic [2:0]    skip_q, skip_d;
  logic [AW-1:0] ram_addr_q, ram_addr_d;
  logic [DW-1:0] ram_dout_q, ram_dout_d;
  logic          ram_rd_q, ram_rd_d;
  logic          ram_wr_q, ram_wr_d;
  logic          cpu_ack_q, cpu_ack_d;
  logic          ld_ack_q, ld_ack_d;
  logic [DW-1:0] cpu_rdata_q, cpu_rdata_d;
  logic          wp_hit;
  logic          ld_forced;

  // Unsigned wrap-around range test: one subtract, one compare.
  assign wp_hit    = WP_EN && ((cpu_addr_i - WP_BASE) <= (WP_LIMIT - WP_BASE));
  assign ld_forced = ld_req_i && (skip_q == SKIP_MAX);

  always_comb begin
    state_d     = state_q;
    owner_ld_d  = owner_ld_q;
    is_wr_d     = is_wr_q;
    lat_cnt_d   = lat_cnt_q;
    skip_d      = skip_q;
    ram_addr_d  = ram_addr_q;
    ram_dout_d  = ram_dout_q;
    cpu_rdata_d = cpu_rdata_q;
    ram_rd_d    = 1'b0;
    ram_wr_d    = 1'b0;
    cpu_ack_d   = 1'b0;
    ld_ack_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (!ld_req_i) skip_d = 3'd0;
        if (cpu_req_i && !ld_forced) begin
          owner_ld_d = 1'b0;
          is_wr_d    = cpu_we_i;
          ram_addr_d = cpu_addr_i;
          ram_dout_d = cpu_wdata_i;
          ram_wr_d   = cpu_we_i && !wp_hit;
          ram_rd_d   = !cpu_we_i;
          if (ld_req_i && (skip_q < SKIP_MAX)) skip_d = skip_q + 3'd1;
          state_d    = S_ACCESS;
        end else if (ld_req_i) begin
          owner_ld_d = 1'b1;
          is_wr_d    = 1'b1;
          ram_addr_d = ld_addr_i;
          ram_dout_d = ld_wdata_i;
          ram_wr_d   = 1'b1;
          skip_d     = 3'd0;
          state_d    = S_ACCESS;
        end
      end
      S_ACCESS: begin
        lat_cnt_d = LAT_LAST;
        if (is_wr_q) begin
          cpu_ack_d = !owner_ld_q;
          ld_ack_d  = owner_ld_q;
          state_d   = S_DONE;
        end else begin
          state_d   = S_LAT;
        end
      end
      S_LAT: begin
        if (lat_cnt_q == 3'd0) begin
          cpu_rdata_d = ram_din_i;
          cpu_ack_d   = !owner_ld_q;
          ld_ack_d    = owner_ld_q;
          state_d     = S_DONE;
        end else begin
          lat_cnt_d   = lat_cnt_q - 3'd1;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge sys_clock) begin
    if (RESET) begin
      state_q     <= S_IDLE;
      owner_ld_q  <= 1'b0;
      is_wr_q     <= 1'b0;
      lat_cnt_q   <= 3'd0;
      skip_q      <= 3'd0;
      ram_addr_q  <= '0;
      ram_dout_q  <= '0;
      ram_rd_q    <= 1'b0;
      ram_wr_q    <= 1'b0;
      cpu_ack_q   <= 1'b0;
      ld_ack_q    <= 1'b0;
      cpu_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      owner_ld_q  <= owner_ld_d;
      is_wr_q     <= is_wr_d;
      lat_cnt_q   <= lat_cnt_d;
      skip_q      <= skip_d;
      ram_addr_q  <= ram_addr_d;
      ram_dout_q  <= ram_dout_d;
      ram_rd_q    <= ram_rd_d;
      ram_wr_q    <= ram_wr_d;
      cpu_ack_q   <= cpu_ack_d;
      ld_ack_q    <= ld_ack_d;
      cpu_rdata_q <= cpu_rdata_d;
    end
  end

  assign ram_addr_o  = ram_addr_q;
  assign ram_dout_o  = ram_dout_q;
  assign ram_rd_o    = ram_rd_q;
  assign ram_wr_o    = ram_wr_q;
  assign cpu_ack_o   = cpu_ack_q;
  assign ld_ack_o    = ld_ack_q;
  assign cpu_rdata_o = cpu_rdata_q;
  assign cpu_wait_o  = cpu_req_i & ~cpu_ack_q;

endmodule

// File: tb/tb_lm80c_ram_arbiter.sv
// tb/tb_lm80c_ram_arbiter.sv - Self-checking bench for lm80c_ram_arbiter.
// Build with ARB_WRITE_PROTECT_EN defined to exercise the write-protect window.
module tb_lm80c_ram_arbiter;
  localparam int RAM_LAT = 1;

  logic        sys_clock = 1'b0;
  logic        RESET = 1'b1;
  logic        cpu_req = 1'b0, cpu_we = 1'b0;
  logic [15:0] cpu_addr = '0;
  logic [7:0]  cpu_wdata = '0;
  logic [7:0]  cpu_rdata;
  logic        cpu_ack, cpu_wait;
  logic        ld_req = 1'b0;
  logic [15:0] ld_addr = '0;
  logic [7:0]  ld_wdata = '0;
  logic        ld_ack;
  logic [15:0] ram_addr;
  logic [7:0]  ram_dout, ram_din;
  logic        ram_rd, ram_wr;

  lm80c_ram_arbiter #(.RAM_LAT(RAM_LAT)) dut (
    .sys_clock(sys_clock), .RESET(RESET),
    .cpu_req_i(cpu_req), .cpu_we_i(cpu_we), .cpu_addr_i(cpu_addr), .cpu_wdata_i(cpu_wdata),
    .cpu_rdata_o(cpu_rdata), .cpu_ack_o(cpu_ack), .cpu_wait_o(cpu_wait),
    .ld_req_i(ld_req), .ld_addr_i(ld_addr), .ld_wdata_i(ld_wdata), .ld_ack_o(ld_ack),
    .ram_addr_o(ram_addr), .ram_dout_o(ram_dout), .ram_din_i(ram_din),
    .ram_rd_o(ram_rd), .ram_wr_o(ram_wr)
  );

  initial forever #5 sys_clock = ~sys_clock;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge sys_clock) cyc <= cyc + 1;

  // External RAM model: combinational read of the held address, write on strobe.
  logic [7:0] mem [0:65535];
  bit clr_mem = 1'b1, preload = 1'b0;
  always @(posedge sys_clock) begin
    if (clr_mem) begin
      for (int i = 0; i < 65536; i++) mem[i] <= 8'h00;
    end else begin
      if (preload) mem[16'h8001] <= 8'h3C;
      if (ram_wr) mem[ram_addr] <= ram_dout;
    end
  end
  assign ram_din = mem[ram_addr];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  function automatic bit prot(input bit is_ld, input bit we, input logic [15:0] a);
`ifdef ARB_WRITE_PROTECT_EN
    return !is_ld && we && (a <= 16'h7FFF);
`else
    return 1'b0 & is_ld & we & a[0];
`endif
  endfunction

  // One isolated transaction; c0 is the first cycle with req high (n=0).
  task automatic do_txn(input bit is_ld, input bit we, input logic [15:0] addr, input logic [7:0] data,
                        output int lat, output int rdat, output int nwr, output int nrd, output int bad);
    @(posedge sys_clock); #1;
    if (is_ld) begin
      ld_req = 1'b1; ld_addr = addr; ld_wdata = data;
    end else begin
      cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = data;
    end
    lat = -1; rdat = 0; nwr = 0; nrd = 0; bad = 0;
    for (int n = 0; n < 20; n++) begin
      @(negedge sys_clock);
      if (ram_wr) begin nwr++; if (n != 1 || ram_addr !== addr || ram_dout !== data) bad++; end
      if (ram_rd) begin nrd++; if (n != 1 || ram_addr !== addr) bad++; end
      if (ram_wr && ram_rd) bad++;
      if (cpu_wait !== (cpu_req && !cpu_ack)) bad++;
      if (is_ld ? cpu_ack : ld_ack) bad++;
      if (is_ld ? ld_ack : cpu_ack) begin
        lat = n; rdat = int'(cpu_rdata);
        break;
      end
    end
    @(posedge sys_clock); #1;
    cpu_req = 1'b0; ld_req = 1'b0;
    @(negedge sys_clock);
    if (cpu_ack || ld_ack || ram_wr || ram_rd) bad++;
  endtask

  typedef struct {
    bit          is_ld;
    bit          we;
    logic [15:0] addr;
    logic [7:0]  data;
    logic [7:0]  exp_rd;
  } vec_t;

  localparam int NV = 12;
  vec_t vecs [NV];
  logic [7:0] ref_mem [logic [15:0]];

  initial begin
    int lat, rdat, nwr, nrd, bad, got, last, t;
    vec_t v;

    vecs[0]  = '{0, 1, 16'h8000, 8'hA5, 8'h00};
    vecs[1]  = '{0, 0, 16'h8001, 8'h00, 8'h3C};
    vecs[2]  = '{0, 0, 16'h8000, 8'h00, 8'hA5};
    vecs[3]  = '{0, 1, 16'h1234, 8'h11, 8'h00};
    vecs[4]  = '{1, 1, 16'h1234, 8'h22, 8'h00};
    vecs[5]  = '{0, 0, 16'h1234, 8'h00, 8'h22};
    vecs[6]  = '{0, 1, 16'h0040, 8'h33, 8'h00};
    vecs[7]  = '{0, 0, 16'h0040, 8'h00, prot(1'b0, 1'b1, 16'h0040) ? 8'h00 : 8'h33};
    vecs[8]  = '{0, 1, 16'hFFFF, 8'h7E, 8'h00};
    vecs[9]  = '{0, 0, 16'hFFFF, 8'h00, 8'h7E};
    vecs[10] = '{1, 1, 16'h7FFF, 8'hC3, 8'h00};
    vecs[11] = '{0, 0, 16'h7FFF, 8'h00, 8'hC3};

    @(posedge sys_clock); #1 clr_mem = 1'b0; preload = 1'b1;
    @(posedge sys_clock); #1 preload = 1'b0;
    repeat (2) @(posedge sys_clock);
    @(negedge sys_clock);
    check("rst_ram_addr", int'(ram_addr), 0);
    check("rst_ram_dout", int'(ram_dout), 0);
    check("rst_strobes", int'({ram_rd, ram_wr}), 0);
    check("rst_acks", int'({cpu_ack, ld_ack}), 0);
    check("rst_cpu_rdata", int'(cpu_rdata), 0);
    RESET = 1'b0;

    // Directed vector table
    for (int i = 0; i < NV; i++) begin
      v = vecs[i];
      do_txn(v.is_ld, v.we, v.addr, v.data, lat, rdat, nwr, nrd, bad);
      check($sformatf("vec%0d_latency", i), lat, v.we ? 2 : 2 + RAM_LAT);
      check($sformatf("vec%0d_wr_pulses", i), nwr, (v.we && !prot(v.is_ld, v.we, v.addr)) ? 1 : 0);
      check($sformatf("vec%0d_rd_pulses", i), nrd, v.we ? 0 : 1);
      check($sformatf("vec%0d_protocol", i), bad, 0);
      if (!v.we) check($sformatf("vec%0d_rdata", i), rdat, int'(v.exp_rd));
    end

    // Both requesters held: four CPU grants, then the loader is forced through
    @(posedge sys_clock); #1;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'hA000; cpu_wdata = 8'h5C;
    ld_req = 1'b1; ld_addr = 16'h9000; ld_wdata = 8'h99;
    got = 0; last = -1; t = 0;
    while (got < 15 && t < 200) begin
      @(negedge sys_clock); t++;
      check("arb_single_ack", int'(cpu_ack & ld_ack), 0);
      if (cpu_ack || ld_ack) begin
        check($sformatf("arb_grant%0d_is_ld", got), int'(ld_ack), (got % 5 == 4) ? 1 : 0);
        if (last >= 0) check("arb_gap", cyc - last, 3);
        last = cyc; got++;
      end
    end
    check("arb_grant_count", got, 15);
    @(posedge sys_clock); #1 cpu_req = 1'b0; ld_req = 1'b0;
    repeat (2) @(posedge sys_clock);

    // Loader burst of 16 bytes, address changed the cycle after each ack
    @(posedge sys_clock); #1;
    ld_req = 1'b1; ld_addr = 16'h0000; ld_wdata = 8'h5A;
    got = 0; last = -1; t = 0;
    while (got < 16 && t < 200) begin
      @(negedge sys_clock); t++;
      if (ld_ack) begin
        if (last >= 0) check("ld_gap", cyc - last, 3);
        last = cyc; got++;
        @(posedge sys_clock); #1;
        if (got < 16) begin ld_addr = 16'(got); ld_wdata = 8'h5A ^ 8'(got); end
        else ld_req = 1'b0;
      end
    end
    check("ld_ack_count", got, 16);
    repeat (2) @(posedge sys_clock);
    for (int i = 0; i < 16; i++) check($sformatf("ld_mem%0d", i), int'(mem[i]), int'(8'h5A ^ 8'(i)));

    // Reset during LAT of a CPU read
    @(posedge sys_clock); #1;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h8001;
    repeat (3) @(negedge sys_clock);
    RESET = 1'b1; cpu_req = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge sys_clock);
      check($sformatf("rstlat%0d_rd_ack", k), int'({ram_rd, ram_wr, cpu_ack, ld_ack}), 0);
    end
    check("rstlat_rdata", int'(cpu_rdata), 0);
    RESET = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge sys_clock);
      check($sformatf("postrst%0d_quiet", k), int'({ram_rd, ram_wr, cpu_ack, ld_ack}), 0);
    end
    do_txn(1'b0, 1'b0, 16'h8001, 8'h00, lat, rdat, nwr, nrd, bad);
    check("postrst_latency", lat, 2 + RAM_LAT);
    check("postrst_rdata", rdat, 8'h3C);
    check("postrst_protocol", bad, 0);

    // Random isolated transactions against a byte-level memory model
    for (int k = 0; k < 40; k++) begin
      bit is_ld, we;
      logic [15:0] a;
      logic [7:0] d;
      int exp_rd;
      repeat ($urandom_range(0, 2)) @(posedge sys_clock);
      is_ld = ($urandom_range(0, 3) == 0);
      we = is_ld ? 1'b1 : ($urandom_range(0, 1) == 1);
      a = (($urandom_range(0, 1) == 1) ? 16'hC000 : 16'h0100) + 16'($urandom_range(0, 15));
      d = 8'($urandom);
      exp_rd = ref_mem.exists(a) ? int'(ref_mem[a]) : 0;
      do_txn(is_ld, we, a, d, lat, rdat, nwr, nrd, bad);
      check($sformatf("rnd%0d_latency", k), lat, we ? 2 : 2 + RAM_LAT);
      check($sformatf("rnd%0d_wr_pulses", k), nwr, (we && !prot(is_ld, we, a)) ? 1 : 0);
      check($sformatf("rnd%0d_protocol", k), bad, 0);
      if (we && !prot(is_ld, we, a)) ref_mem[a] = d;
      if (!we) check($sformatf("rnd%0d_rdata", k), rdat, exp_rd);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lm80c_ram_arbiter.md
Name: lm80c_ram_arbiter

Overview:
Arbitrates the single 8-bit system RAM port between two requesters: the Z80 core and the ROM/program loader, which writes downloaded images into RAM. It sequences each access through a small FSM and stalls the CPU via its WAIT input until its access completes. It sits between the CPU bus decode and the external RAM interface (ram_addr/ram_dout/ram_din/ram_rd/ram_wr).

Parameters:
AW, 16, address width
DW, 8, data width
RAM_LAT, 1, RAM read latency in cycles (legal range 1..7)
LD_MAX_SKIP, 4, consecutive CPU grants tolerated while the loader waits before the loader is forced through
WP_BASE, 16'h0000, first write-protected address (optional feature only)
WP_LIMIT, 16'h7FFF, last write-protected address (optional feature only)

Ports:
sys_clock  in  1  system clock
RESET  in  1  reset, synchronous, active-high
cpu_req  in  1  CPU memory request, level, held until cpu_ack
cpu_we  in  1  1 = write, 0 = read
cpu_addr  in  AW  CPU address
cpu_wdata  in  DW  CPU write data
cpu_rdata  out  DW  CPU read data, valid when cpu_ack = 1, held until next CPU read completes
cpu_ack  out  1  one-cycle completion pulse
cpu_wait  out  1  CPU WAIT, = cpu_req & ~cpu_ack (combinational)
ld_req  in  1  loader write request, level, held until ld_ack
ld_addr  in  AW  loader address
ld_wdata  in  DW  loader data
ld_ack  out  1  one-cycle completion pulse
ram_addr  out  AW  RAM address (registered)
ram_dout  out  DW  RAM write data (registered)
ram_din  in  DW  RAM read data
ram_rd  out  1  RAM read strobe
ram_wr  out  1  RAM write strobe

Behaviour:
- Reset values: ram_addr=0, ram_dout=0, ram_rd=0, ram_wr=0, cpu_ack=0, ld_ack=0, cpu_rdata=0, skip counter=0, state=IDLE.
- FSM states: IDLE, ACCESS, LAT, DONE. The owner register (CPU/LD) is latched on leaving IDLE.
- IDLE: requests are sampled here only. Neither pending -> stay. One pending -> grant it. Both pending -> grant CPU unless skip_cnt == LD_MAX_SKIP, then grant loader. On grant, register addr/data and go to ACCESS.
- ACCESS: exactly one cycle. ram_wr=1 for writes, ram_rd=1 for reads. Write -> DONE. Read -> LAT.
- LAT: RAM_LAT cycles. ram_din is captured into cpu_rdata at the end of the last LAT cycle -> DONE.
- DONE: the owner's ack = 1 for this cycle only -> IDLE. The requester drops or changes req in the cycle after ack. IDLE samples req on the cycle following DONE.
- Latency from the req-sampled IDLE cycle c0: write ack in c2; read ack in c2+RAM_LAT. Back-to-back throughput: write every 3 cycles, read every 3+RAM_LAT cycles.
- Loader requests are always writes. The loader never reads.
- skip_cnt (3-bit saturating):
  - +1 on each CPU grant made while ld_req = 1.
  - Cleared on loader grant, or on any IDLE cycle with ld_req = 0.
  - Saturates at LD_MAX_SKIP.
- ram_rd and ram_wr are never both 1. Strobes are only ever 1 in ACCESS.
- Reset mid-operation: next edge returns to IDLE, strobes drop, and no ack is issued for the aborted access.
- A requester dropping req before ack is illegal. Behaviour is undefined, but the FSM still completes the latched access.

Optional Feature:
Macro ARB_WRITE_PROTECT_EN.
- Defined: CPU writes with WP_BASE <= cpu_addr <= WP_LIMIT still go through IDLE->ACCESS->DONE with identical timing and cpu_ack, but ram_wr stays 0 (ROM shadow protection). Loader writes are never protected.
- Not defined: all writes assert ram_wr. WP_BASE and WP_LIMIT are unused.

Test Plan:
1. Reset, then CPU write addr 16'h8000 data 8'hA5 -> ram_wr=1 only in c1 with ram_addr=8000, ram_dout=A5; cpu_ack=1 in c2; cpu_wait 1 in c0..c1 and 0 in c2.
2. CPU read 16'h8001 with RAM model returning 8'h3C, RAM_LAT=1 -> ram_rd=1 in c1; cpu_ack and cpu_rdata=3C in c3.
3. cpu_req and ld_req asserted continuously, CPU re-requesting immediately after each ack -> 4 CPU grants, then 1 loader grant, repeating; the loader is never skipped more than 4 times.
4. Loader alone writes 16 bytes to 0x0000..0x000F -> 16 ld_ack pulses 3 cycles apart; RAM contents match.
5. Assert RESET during LAT of a CPU read -> next cycle ram_rd=0, no cpu_ack, state IDLE; a fresh request after reset completes normally.
6. With ARB_WRITE_PROTECT_EN: CPU write to 16'h1234 -> cpu_ack in c2 and ram_wr stays 0. Loader write to 16'h1234 -> ram_wr=1. CPU write to 16'h8000 -> ram_wr=1.
